// File: rtl/demux_pkg.sv
// Shared types and helpers for the buffered 1-to-8 demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

   localparam int SEL_W  = 3;
   localparam int NCH    = 8;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   // Buffer occupancy doubles as the control state: the encoding is the count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

   // One buffered word at the default data width.
   typedef struct packed {
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] data;
   } entry_t;

   function automatic logic [NCH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
      logic [NCH-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO holding {sel, data} entries; occupancy is the FSM state.
// Latency: a push is visible at o_head after the write edge, no fall-through.
// Backpressure: pushes are ignored while FULL, even if a pop happens that cycle.
//
// Ports: clk/rst_n, i_push + i_entry (write side), i_pop (read side),
//        o_state (EMPTY/ONE/FULL), o_head (entry at the read pointer).
module demux_fifo2
   import demux_pkg::*;
#(
   parameter int ENT_W = SEL_W + DATA_W,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [ENT_W-1:0] i_entry,
   input  logic             i_pop,
   output fifo_state_t      o_state,
   output logic [ENT_W-1:0] o_head
);

   localparam int PTR_W = $clog2(DEPTH);

   fifo_state_t      r_state;
   fifo_state_t      w_state_nxt;
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [ENT_W-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;

   // Guard both sides so a misbehaving caller can never over/underflow.
   assign w_push = i_push & (r_state != FULL);
   assign w_pop  = i_pop  & (r_state != EMPTY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_push)            w_state_nxt = ONE;
         ONE: begin
            if (w_push && !w_pop)      w_state_nxt = FULL;
            else if (w_pop && !w_push) w_state_nxt = EMPTY;
         end
         FULL:  if (w_pop)             w_state_nxt = ONE;
         default:                      w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PTR_W'(1);
         if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      end
   end

   // Storage is never read while EMPTY, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_entry;
   end

   assign o_state = r_state;
   assign o_head  = r_mem[r_rp];

endmodule

// File: rtl/demux_8ch_buf.sv
// Buffered 1-to-8 demux: one valid/ready input steered to one of eight outputs.
// Latency: 1 cycle minimum (push at edge k, earliest pop at edge k+1).
// Backpressure: in_ready drops only when FULL; a stalled head blocks all channels.
//
// Ports: clk/rst_n; in_valid/in_ready/in_sel/in_data (producer side);
//        out_valid (one-hot)/out_ready (per channel)/out_data (shared);
//        deliv_cnt (wrapping count of delivered words).
module demux_8ch_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [NCH-1:0]   out_valid,
   input  logic [NCH-1:0]   out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] deliv_cnt
);

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [WIDTH-1:0] data;
   } ent_t;

   ent_t             w_in_ent;
   ent_t             w_head;
   fifo_state_t      w_state;
   logic             w_push;
   logic             w_pop;
   logic             w_nonempty;
   logic [CNT_W-1:0] r_deliv_cnt;

   assign w_in_ent.sel  = in_sel;
   assign w_in_ent.data = in_data;

   // in_ready comes from state only, keeping out_ready off the input path.
   assign in_ready   = (w_state != FULL);
   assign w_push     = in_valid & in_ready;
   assign w_nonempty = (w_state != EMPTY);

   // Ready on a channel other than the head's is masked by the one-hot valid.
   assign w_pop = |(out_valid & out_ready);

   demux_fifo2 #(
      .ENT_W ($bits(ent_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_entry (w_in_ent),
      .i_pop   (w_pop),
      .o_state (w_state),
      .o_head  (w_head)
   );

   assign out_valid = w_nonempty ? sel_to_onehot(w_head.sel) : '0;
   assign out_data  = w_nonempty ? w_head.data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deliv_cnt <= '0;
      end else if (w_pop) begin
         r_deliv_cnt <= r_deliv_cnt + CNT_W'(1);
      end
   end

   assign deliv_cnt = r_deliv_cnt;

endmodule

// File: tb/tb_demux_8ch_buf.sv
// Directed bench for demux_8ch_buf with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Ends with a single pass-count summary line.
module tb_demux_8ch_buf;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_sel;
   logic [31:0] in_data;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [31:0] out_data;
   logic [15:0] deliv_cnt;

   int n_total;
   int n_pass;

   demux_8ch_buf #(.WIDTH(32), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .deliv_cnt (deliv_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
         $error("check %s got %h want %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_total   = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 3'd0;
      in_data   = 32'h0;
      out_ready = 8'h00;

      // ---------------- reset state ----------------
      tick();
      tick();
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'h00);
      chk("rst_out_data",  out_data,       32'h0);
      chk("rst_deliv",     32'(deliv_cnt), 32'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- single word to channel 5 ----------------
      in_valid  = 1'b1; in_sel = 3'd5; in_data = 32'hDEADBEEF;
      out_ready = 8'h20;
      tick();
      in_valid = 1'b0;
      chk("t1_valid",    32'(out_valid), 32'h20);
      chk("t1_data",     out_data,       32'hDEADBEEF);
      chk("t1_in_ready", 32'(in_ready),  32'd1);
      tick();
      chk("t1_empty_valid", 32'(out_valid), 32'h00);
      chk("t1_empty_data",  out_data,       32'h0);
      chk("t1_deliv",       32'(deliv_cnt), 32'd1);

      // idle input lines wiggling with in_valid low must do nothing
      in_sel = 3'd2; in_data = 32'h12345678;
      tick();
      in_sel = 3'd7; in_data = 32'h87654321;
      tick();
      chk("idle_valid", 32'(out_valid), 32'h00);
      chk("idle_deliv", 32'(deliv_cnt), 32'd1);

      // ---------------- fill, head-of-line blocking ----------------
      out_ready = 8'h00;
      in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h33;
      tick();
      in_sel = 3'd6; in_data = 32'h66;
      tick();
      in_valid = 1'b0;
      chk("full_in_ready", 32'(in_ready),  32'd0);
      chk("full_valid",    32'(out_valid), 32'h08);
      chk("full_data",     out_data,       32'h33);
      out_ready = 8'h40;   // ready on the non-head channel only
      tick();
      chk("hol_valid",    32'(out_valid), 32'h08);
      chk("hol_data",     out_data,       32'h33);
      chk("hol_in_ready", 32'(in_ready),  32'd0);
      chk("hol_deliv",    32'(deliv_cnt), 32'd1);
      out_ready = 8'h08;
      tick();
      chk("pop3_valid",    32'(out_valid), 32'h40);
      chk("pop3_data",     out_data,       32'h66);
      chk("pop3_in_ready", 32'(in_ready),  32'd1);
      chk("pop3_deliv",    32'(deliv_cnt), 32'd2);

      // ---------------- count==1: simultaneous push and pop ----------------
      in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h11;
      out_ready = 8'h40;
      tick();
      chk("pp_valid",    32'(out_valid), 32'h02);
      chk("pp_data",     out_data,       32'h11);
      chk("pp_in_ready", 32'(in_ready),  32'd1);
      chk("pp_deliv",    32'(deliv_cnt), 32'd3);

      // ---------------- FULL with pop: push not admitted that cycle ----------------
      out_ready = 8'h00;
      in_sel = 3'd2; in_data = 32'h22;
      tick();
      chk("f2_in_ready", 32'(in_ready), 32'd0);
      in_sel = 3'd4; in_data = 32'h44;   // offered while FULL
      out_ready = 8'h02;
      tick();
      chk("fp_in_ready", 32'(in_ready),  32'd1);
      chk("fp_valid",    32'(out_valid), 32'h04);
      chk("fp_data",     out_data,       32'h22);
      chk("fp_deliv",    32'(deliv_cnt), 32'd4);
      out_ready = 8'h00;                 // 0x44 still offered, now accepted
      tick();
      in_valid = 1'b0;
      chk("fp2_in_ready", 32'(in_ready),  32'd0);
      chk("fp2_valid",    32'(out_valid), 32'h04);
      out_ready = 8'h04;
      tick();
      chk("dr_valid", 32'(out_valid), 32'h10);
      chk("dr_data",  out_data,       32'h44);
      chk("dr_deliv", 32'(deliv_cnt), 32'd5);
      out_ready = 8'h10;
      tick();
      chk("dr_empty", 32'(out_valid), 32'h00);
      chk("dr_deliv2", 32'(deliv_cnt), 32'd6);

      // ---------------- streaming, alternating sel 0/7 ----------------
      out_ready = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_sel   = (i % 2 == 1) ? 3'd7 : 3'd0;
         in_data  = 32'h100 + 32'(i);
         tick();
         chk("st_onehot",   32'($countones(out_valid)), 32'd1);
         chk("st_valid",    32'(out_valid), (i % 2 == 1) ? 32'h80 : 32'h01);
         chk("st_data",     out_data,       32'h100 + 32'(i));
         chk("st_in_ready", 32'(in_ready),  32'd1);
         chk("st_deliv",    32'(deliv_cnt), 32'd6 + 32'(i));
      end
      in_valid = 1'b0;
      tick();
      chk("st_end_valid", 32'(out_valid), 32'h00);
      chk("st_end_deliv", 32'(deliv_cnt), 32'd16);

      // ---------------- async reset mid-stream while FULL ----------------
      out_ready = 8'h00;
      in_valid = 1'b1; in_sel = 3'd1; in_data = 32'hAA;
      tick();
      in_sel = 3'd2; in_data = 32'hBB;
      tick();
      in_valid = 1'b0;
      chk("pr_in_ready", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid",    32'(out_valid), 32'h00);
      chk("ar_in_ready", 32'(in_ready),  32'd1);
      chk("ar_deliv",    32'(deliv_cnt), 32'd0);
      chk("ar_data",     out_data,       32'h0);
      tick();
      rst_n = 1'b1;
      out_ready = 8'hFF;
      tick();
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'h00);
      chk("post_rst_deliv", 32'(deliv_cnt), 32'd0);

      // ---------------- deliv_cnt wrap after 65536 deliveries ----------------
      in_valid = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         in_sel  = 3'(i);
         in_data = 32'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("wrap_pre", 32'(deliv_cnt), 32'hFFFF);
      chk("wrap_head", out_data, 32'd65535);
      tick();
      chk("wrap_zero",  32'(deliv_cnt), 32'd0);
      chk("wrap_empty", 32'(out_valid), 32'h00);
      in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h5;
      tick();
      in_valid = 1'b0;
      tick();
      chk("wrap_one", 32'(deliv_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
